// File: rtl/uart_pkg.sv
// uart_pkg: parity modes, shared RX/TX state encoding and the
// parity helper used by the parameterised UART.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_ODD  = 2'd1;
  localparam logic [1:0] PAR_EVEN = 2'd2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } uart_state_e;

  // Narrow payloads arrive zero-extended, which leaves the XOR intact.
  function automatic logic par_bit(
    input logic [7:0] d,
    input logic [1:0] mode
  );
    logic p;
    case (mode)
      PAR_ODD:  p = ~(^d);
      PAR_EVEN: p = ^d;
      default:  p = 1'b0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// uart_fifo: circular show-ahead FIFO with registered full/empty
// flags that reflect the occupancy after each edge.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] w_data,
  output logic [WIDTH-1:0] r_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [AW:0]      count_n;
  logic             do_push;
  logic             do_pop;

  // A push on a full FIFO is dropped even when a pop frees a slot.
  assign do_pop  = pop && !empty;
  assign do_push = push && !full;
  assign r_data  = mem[rd_ptr];

  always_comb begin
    count_n = count;
    if (do_push && !do_pop)
      count_n = count + 1'b1;
    else if (do_pop && !do_push)
      count_n = count - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= w_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count_n;
      full  <= (count_n == (AW+1)'(DEPTH));
      empty <= (count_n == '0);
    end
  end

endmodule

// File: rtl/uart_param.sv
// uart_param: parameterised UART with 16x oversampling receiver,
// transmitter, RX/TX FIFOs and sticky line-error flags.
module uart_param
  import uart_pkg::*;
#(
  parameter int DIVISOR    = 163,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 Rx,
  output logic                 Tx,
  input  logic                 we,
  input  logic [DATA_BITS-1:0] w_data,
  output logic                 full,
  input  logic                 re,
  output logic [DATA_BITS-1:0] r_data,
  output logic                 rx_empty,
  output logic                 tx_busy,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  input  logic                 clr_err
);

  localparam logic [1:0] PMODE = 2'(PARITY);
  localparam bit HAS_PAR = (PMODE != PAR_NONE);
  localparam int DW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam int BIT_CLKS = 16 * DIVISOR;
  localparam int CW = $clog2(BIT_CLKS);
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);
  localparam logic LAST_STOP = 1'(STOP_BITS - 1);

  logic          rx_s1;
  logic          rx_s2;
  logic [DW-1:0] div_cnt;
  logic          tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= Rx;
      rx_s2 <= rx_s1;
    end
  end

  assign tick = (div_cnt == DW'(DIVISOR - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      div_cnt <= '0;
    else
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
  end

  uart_state_e          rx_st;
  logic [3:0]           rx_s;
  logic [2:0]           rx_n;
  logic [DATA_BITS-1:0] rx_sh;
  logic                 mid;
  logic                 rx_push;
  logic                 rx_full;
  logic                 par_set;
  logic                 frm_set;
  logic                 ovr_set;

  assign mid     = tick && (rx_s == 4'd15);
  assign rx_push = (rx_st == STOP) && mid && rx_s2;
  assign frm_set = (rx_st == STOP) && mid && !rx_s2;
  assign ovr_set = rx_push && rx_full;
  assign par_set = (rx_st == PAR) && mid &&
                   (rx_s2 != par_bit(8'(rx_sh), PMODE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_st <= IDLE;
      rx_s  <= '0;
      rx_n  <= '0;
      rx_sh <= '0;
    end else begin
      unique case (rx_st)
        IDLE: if (!rx_s2) begin
          rx_st <= START;
          rx_s  <= '0;
        end
        // Mid-start re-check rejects short glitches.
        START: if (tick) begin
          if (rx_s == 4'd7) begin
            rx_s  <= '0;
            rx_n  <= '0;
            rx_st <= rx_s2 ? IDLE : DATA;
          end else
            rx_s <= rx_s + 1'b1;
        end
        DATA: if (tick) begin
          rx_s <= rx_s + 1'b1;
          if (rx_s == 4'd15) begin
            rx_sh <= {rx_s2, rx_sh[DATA_BITS-1:1]};
            rx_n  <= rx_n + 1'b1;
            if (rx_n == LAST_BIT)
              rx_st <= HAS_PAR ? PAR : STOP;
          end
        end
        PAR: if (tick) begin
          rx_s <= rx_s + 1'b1;
          if (rx_s == 4'd15)
            rx_st <= STOP;
        end
        STOP: if (tick) begin
          rx_s <= rx_s + 1'b1;
          if (rx_s == 4'd15)
            rx_st <= IDLE;
        end
        default: rx_st <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      parity_err <= par_set | (parity_err & ~clr_err);
      frame_err  <= frm_set | (frame_err & ~clr_err);
      overrun    <= ovr_set | (overrun & ~clr_err);
    end
  end

  uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (rx_push),
    .pop    (re),
    .w_data (rx_sh),
    .r_data (r_data),
    .full   (rx_full),
    .empty  (rx_empty)
  );

  uart_state_e          tx_st;
  logic [CW-1:0]        tx_cnt;
  logic [2:0]           tx_n;
  logic                 tx_stop_n;
  logic [DATA_BITS-1:0] tx_sh;
  logic [DATA_BITS-1:0] tx_head;
  logic                 tx_par;
  logic                 tx_empty;
  logic                 bit_end;
  logic                 tx_load;

  // Loading straight out of the last stop bit avoids an idle gap.
  assign bit_end = (tx_cnt == CW'(BIT_CLKS - 1));
  assign tx_load = !tx_empty &&
                   ((tx_st == IDLE) ||
                    ((tx_st == STOP) && bit_end &&
                     (tx_stop_n == LAST_STOP)));
  assign tx_busy = (tx_st != IDLE) || !tx_empty;

  uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (we),
    .pop    (tx_load),
    .w_data (w_data),
    .r_data (tx_head),
    .full   (full),
    .empty  (tx_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_st     <= IDLE;
      tx_cnt    <= '0;
      tx_n      <= '0;
      tx_stop_n <= 1'b0;
      tx_sh     <= '0;
      tx_par    <= 1'b0;
      Tx        <= 1'b1;
    end else if (tx_load) begin
      tx_st  <= START;
      tx_cnt <= '0;
      tx_sh  <= tx_head;
      tx_par <= par_bit(8'(tx_head), PMODE);
      Tx     <= 1'b0;
    end else if (tx_st != IDLE) begin
      tx_cnt <= bit_end ? '0 : tx_cnt + 1'b1;
      if (bit_end) begin
        unique case (tx_st)
          START: begin
            tx_st <= DATA;
            tx_n  <= '0;
            Tx    <= tx_sh[0];
            tx_sh <= tx_sh >> 1;
          end
          DATA: if (tx_n == LAST_BIT) begin
            tx_st     <= HAS_PAR ? PAR : STOP;
            Tx        <= HAS_PAR ? tx_par : 1'b1;
            tx_stop_n <= 1'b0;
          end else begin
            tx_n  <= tx_n + 1'b1;
            Tx    <= tx_sh[0];
            tx_sh <= tx_sh >> 1;
          end
          PAR: begin
            tx_st     <= STOP;
            Tx        <= 1'b1;
            tx_stop_n <= 1'b0;
          end
          STOP: if (tx_stop_n == LAST_STOP)
            tx_st <= IDLE;
          else
            tx_stop_n <= tx_stop_n + 1'b1;
          default: tx_st <= IDLE;
        endcase
      end
    end
  end

endmodule
